// File: rtl/vec_mag_arbiter.sv
// Round-robin packet arbiter sharing one vec_mag_core; results are re-tagged with their channel.
// Optional per-channel packet counters are enabled with `define VEC_MAG_ARB_STATS_EN.
module vec_mag_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int COORD_WIDTH = 8,
  parameter int TDATA_WIDTH = 4*COORD_WIDTH,
  parameter int TAG_DEPTH   = 8,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW = $clog2(TAG_DEPTH)
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_CH*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]             s_axis_tvalid,
  input  logic [NUM_CH-1:0]             s_axis_tlast,
  output logic [NUM_CH-1:0]             s_axis_tready,
  output logic [TDATA_WIDTH-1:0]        c_axis_tdata,
  output logic                          c_axis_tvalid,
  output logic                          c_axis_tlast,
  input  logic                          c_axis_tready,
  input  logic [TDATA_WIDTH-1:0]        r_axis_tdata,
  input  logic                          r_axis_tvalid,
  input  logic                          r_axis_tlast,
  output logic                          r_axis_tready,
  output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [CW-1:0]                 m_axis_tid,
  input  logic                          m_axis_tready,
  output logic [AW:0]                   outstanding,
`ifdef VEC_MAG_ARB_STATS_EN
  input  logic                          stat_clr,
  output logic [NUM_CH*16-1:0]          stat_pkt_cnt,
`endif
  output logic                          err_orphan
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] rr_last_q, rr_last_d;
  logic [CW-1:0] pick, idx;
  logic          found;

  logic [CW-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          orphan_q;
  logic          fifo_full, fifo_empty;
  logic          busy, push, pop;

  logic [TDATA_WIDTH-1:0] ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_unpack
    assign ch_data[i] = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
  end

  assign busy       = (state_q == BUSY);
  assign fifo_full  = (cnt_q == (AW+1)'(TAG_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  assign c_axis_tdata  = ch_data[grant_q];
  assign c_axis_tlast  = s_axis_tlast[grant_q];
  assign c_axis_tvalid = busy & s_axis_tvalid[grant_q] & ~fifo_full;
  assign push          = c_axis_tvalid & c_axis_tready;

  always_comb begin
    s_axis_tready = '0;
    if (busy)
      s_axis_tready[grant_q] = c_axis_tready & ~fifo_full;
  end

  // Search starts just after the last served channel.
  always_comb begin
    found = 1'b0;
    pick  = rr_last_q;
    idx   = rr_last_q;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(rr_last_q) + k) % NUM_CH);
      if (!found && s_axis_tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    unique case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        state_d = BUSY;
      end
      BUSY: if (push && c_axis_tlast) begin
        rr_last_d = grant_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axis_tdata  = r_axis_tdata;
  assign m_axis_tlast  = r_axis_tlast;
  assign m_axis_tid    = tag_mem[rd_ptr_q];
  assign m_axis_tvalid = r_axis_tvalid & ~fifo_empty;
  assign r_axis_tready = m_axis_tready & ~fifo_empty;
  assign pop           = m_axis_tvalid & m_axis_tready;

  assign cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign outstanding = cnt_q;
  assign err_orphan  = orphan_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_last_q <= CW'(NUM_CH - 1);
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      orphan_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (r_axis_tvalid && fifo_empty) orphan_q <= 1'b1;
    end
  end

  // Tag storage needs no reset; occupancy gates every read.
  always_ff @(posedge aclk) begin
    if (push) tag_mem[wr_ptr_q] <= grant_q;
  end

`ifdef VEC_MAG_ARB_STATS_EN
  logic [15:0] pkt_cnt_q [NUM_CH];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_CH; i++) pkt_cnt_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_CH; i++) pkt_cnt_q[i] <= '0;
    end else if (push && c_axis_tlast) begin
      pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 16'd1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_stat
    assign stat_pkt_cnt[i*16 +: 16] = pkt_cnt_q[i];
  end
`endif

endmodule
